cla_nibble_sequencer: RTL and testbench

Multi-cycle WIDTH-bit adder controller that time-shares one external 4-bit carry-lookahead slice (the team's `CLA_4bit` block). It processes one nibble per clock, least significant first, and chains the carry between nibbles through a register. Operands enter and results leave through valid/ready handshakes. The block sits between a requesting datapath and a single CLA slice instance, and it owns all sequencing, carry chaining and result assembly.

---
 rtl/cla_nibble_sequencer_if.sv | 34 +++
 rtl/cla_nibble_sequencer.sv | 108 ++++++++++
 tb/tb_cla_nibble_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cla_nibble_sequencer_if.sv
// rtl/cla_nibble_sequencer_if.sv - operand/result handshakes and CLA slice port bundle
interface cla_nibble_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             all_p;
  logic             busy;
  logic [3:0]       cla_a;
  logic [3:0]       cla_b;
  logic             cla_cin;
  logic [3:0]       cla_s;
  logic             cla_cout;
  logic             cla_pg;
  logic             cla_gg;

  modport master (
    output in_valid, a, b, cin, out_ready, cla_s, cla_cout, cla_pg, cla_gg,
    input  in_ready, out_valid, sum, cout, ovf, all_p, busy, cla_a, cla_b, cla_cin
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready, cla_s, cla_cout, cla_pg, cla_gg,
    output in_ready, out_valid, sum, cout, ovf, all_p, busy, cla_a, cla_b, cla_cin
  );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// rtl/cla_nibble_sequencer.sv - WIDTH-bit adder time-sharing one external 4-bit CLA slice
module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_nibble_sequencer_if.slave  bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic             allp_reg;
  logic [IW-1:0]    idx;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      carry       <= 1'b0;
      allp_reg    <= 1'b0;
      idx         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            carry      <= bus.cin;
            allp_reg   <= 1'b1;
            idx        <= '0;
            state      <= RUN;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        RUN: begin
          sum_reg[4*idx +: 4] <= bus.cla_s;
          carry               <= bus.cla_cout;
          allp_reg            <= allp_reg & bus.cla_pg;
          // idx parks on the last nibble instead of wrapping
          if (idx == LAST) begin
            state       <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.cla_a   = 4'h0;
    bus.cla_b   = 4'h0;
    bus.cla_cin = 1'b0;
    if (state == RUN) begin
      bus.cla_a   = a_reg[4*idx +: 4];
      bus.cla_b   = b_reg[4*idx +: 4];
      bus.cla_cin = carry;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.sum       = sum_reg;
  assign bus.cout      = carry;
  assign bus.all_p     = allp_reg;
  assign bus.ovf       = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);

  // The slice's carry must agree with its own group generate/propagate terms
  a_slice_carry: assert property (@(posedge clk) disable iff (rst)
    bus.cla_cout == (bus.cla_gg | (bus.cla_pg & bus.cla_cin)));
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// tb/tb_cla_nibble_sequencer.sv - scoreboard bench for cla_nibble_sequencer with a behavioural CLA slice
module tb_cla_nibble_sequencer;
  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             allp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cla_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();
  cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic [4:0] slice_full;
  logic [4:0] slice_gen;
  assign slice_full   = {1'b0, bus.cla_a} + {1'b0, bus.cla_b} + {4'b0, bus.cla_cin};
  assign slice_gen    = {1'b0, bus.cla_a} + {1'b0, bus.cla_b};
  assign bus.cla_s    = slice_full[3:0];
  assign bus.cla_cout = slice_full[4];
  assign bus.cla_pg   = &(bus.cla_a ^ bus.cla_b);
  assign bus.cla_gg   = slice_gen[4];

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    exp_t e;
    logic [WIDTH:0] full;
    full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    e.allp = &(x ^ y);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc, output int k);
    int n = 0;
    bus.a = ta; bus.b = tb_v; bus.cin = tc; bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 200) begin tick; n++; end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    end
    tick;
    k = cyc;
    q.push_back(model(ta, tb_v, tc));
    bus.in_valid = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
  endtask

  task automatic wait_valid(output int k);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin tick; n++; end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL out_valid_timeout out_valid=%b required=1", bus.out_valid);
    end
    k = cyc;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.in_valid = 1'b1;
    tick;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.sum !== '0) begin errors++; $display("FAIL rst_sum got=%h exp=0", bus.sum); end
    checks++; if ({bus.cout, bus.ovf, bus.all_p} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {bus.cout, bus.ovf, bus.all_p}); end
    checks++; if ({bus.cla_a, bus.cla_b, bus.cla_cin} !== 9'h0) begin errors++; $display("FAIL rst_cla got=%h exp=0", {bus.cla_a, bus.cla_b, bus.cla_cin}); end
    rst = 1'b0; bus.in_valid = 1'b0;
    tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_release_accept busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_vectors;
    logic [WIDTH-1:0] va [3] = '{16'h0001, 16'h7FFF, 16'hDEAD};
    logic [WIDTH-1:0] vb [3] = '{16'h0000, 16'h0001, 16'hBEEF};
    logic             vc [3] = '{1'b0, 1'b0, 1'b1};
    int k0, k1;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      accept(va[i], vb[i], vc[i], k0);
      wait_valid(k1);
      checks++; if (k1 - k0 != 4) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=4", i, k1 - k0); end
      e = q.pop_front();
      checks++;
      if ({bus.sum, bus.cout, bus.ovf, bus.all_p} !== {e.sum, e.cout, e.ovf, e.allp}) begin
        errors++;
        $display("FAIL vec%0d_result got=%h/%b%b%b exp=%h/%b%b%b", i, bus.sum, bus.cout, bus.ovf, bus.all_p, e.sum, e.cout, e.ovf, e.allp);
      end
      bus.out_ready = 1'b1;
      tick;
      bus.out_ready = 1'b0;
      checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL vec%0d_release valid/ready got=%b exp=01", i, {bus.out_valid, bus.in_ready}); end
    end
  endtask

  task automatic test_ripple;
    int k;
    exp_t e;
    accept(16'hFFFF, 16'h0000, 1'b1, k);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.busy, bus.cla_cin} !== 2'b11) begin errors++; $display("FAIL ripple_cin%0d busy/cin got=%b exp=11", i, {bus.busy, bus.cla_cin}); end
      tick;
    end
    e = q.pop_front();
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.all_p} !== {1'b1, e.sum, e.cout, e.allp}) begin
      errors++;
      $display("FAIL ripple_result got=%b/%h/%b/%b exp=1/%h/%b/%b", bus.out_valid, bus.sum, bus.cout, bus.all_p, e.sum, e.cout, e.allp);
    end
    bus.out_ready = 1'b1; tick; bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int k;
    exp_t e;
    logic [WIDTH-1:0] held;
    accept(16'h1357, 16'h2468, 1'b0, k);
    wait_valid(k);
    held = bus.sum;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.a = WIDTH'($urandom);
      tick;
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.sum} !== {2'b10, held}) begin
        errors++;
        $display("FAIL bp_hold%0d valid/ready/sum got=%b%b/%h exp=10/%h", i, bus.out_valid, bus.in_ready, bus.sum, held);
      end
    end
    e = q.pop_front();
    checks++; if (bus.sum !== e.sum) begin errors++; $display("FAIL bp_sum got=%h exp=%h", bus.sum, e.sum); end
    bus.out_ready = 1'b1; tick; bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release valid/ready/busy got=%b exp=010", {bus.out_valid, bus.in_ready, bus.busy});
    end
  endtask

  task automatic test_reset_mid;
    int k;
    exp_t e;
    accept(16'h1111, 16'h2222, 1'b0, k);
    tick; tick;
    rst = 1'b1; tick; rst = 1'b0;
    void'(q.pop_back());
    checks++;
    if ({bus.busy, bus.in_ready, bus.out_valid, bus.sum, bus.cla_a} !== {3'b010, 16'h0000, 4'h0}) begin
      errors++;
      $display("FAIL midrst busy/ready/valid/sum/cla_a got=%b%b%b/%h/%h exp=010/0000/0", bus.busy, bus.in_ready, bus.out_valid, bus.sum, bus.cla_a);
    end
    accept(16'h1234, 16'h4321, 1'b0, k);
    wait_valid(k);
    e = q.pop_front();
    checks++; if (bus.sum !== e.sum) begin errors++; $display("FAIL midrst_fresh_sum got=%h exp=%h", bus.sum, e.sum); end
    bus.out_ready = 1'b1; tick; bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int got = 0;
    int guard = 0;
    fork
      begin
        int k;
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) tick;
          accept(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), k);
        end
      end
      begin
        exp_t e;
        while (got < 20 && guard < 5000) begin
          bus.out_ready = 1'($urandom);
          if (bus.out_valid === 1'b1 && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL b2b_unexpected sum=%h queue_size=0 exp>0", bus.sum);
            end else begin
              e = q.pop_front();
              if ({bus.sum, bus.cout, bus.ovf, bus.all_p} !== {e.sum, e.cout, e.ovf, e.allp}) begin
                errors++;
                $display("FAIL b2b_result%0d got=%h/%b%b%b exp=%h/%b%b%b", got, bus.sum, bus.cout, bus.ovf, bus.all_p, e.sum, e.cout, e.ovf, e.allp);
              end
            end
            got++;
          end
          tick;
          guard++;
        end
        bus.out_ready = 1'b0;
      end
    join
    checks++; if (got != 20) begin errors++; $display("FAIL b2b_count got=%0d exp=20", got); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    tick; tick;
    test_reset;
    test_vectors;
    test_ripple;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
